// File: rtl/ex_mem_stage.sv
// EX stage datapath (operand forwarding, ALU, branch resolution) feeding the EX/MEM
// pipeline register. All outputs are registered; flush beats stall beats load.
module ex_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Inst_Addr,
    input  logic [63:0] ReadData1,
    input  logic [63:0] ReadData2,
    input  logic [63:0] ImmediateData,
    input  logic [4:0]  rd,
    input  logic [3:0]  Funct,
    input  logic [1:0]  WB,
    input  logic [2:0]  M,
    input  logic [1:0]  ALUOp,
    input  logic        ALUSrc,
    input  logic        valid_in,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [63:0] WbFwdData,
    input  logic        stall,
    input  logic        flush,
    output logic [1:0]  WB_Out,
    output logic [2:0]  M_Out,
    output logic [4:0]  rd_Out,
    output logic        valid_out,
    output logic [63:0] ALU_Result_Out,
    output logic [63:0] WriteData_Out,
    output logic        Zero_Out,
    output logic [63:0] Branch_Target_Out,
    output logic        BranchTaken_Out
);

    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra
    } alu_op_e;

    logic [63:0] op_a;
    logic [63:0] fwd_b;
    logic [63:0] alu_b;
    logic [5:0]  shamt;
    alu_op_e     alu_op;
    logic [63:0] alu_result;
    logic        alu_zero;
    logic [63:0] branch_target;
    logic        branch_taken;

    // 10 takes the registered EX/MEM result even if it is a bubble; hazard unit owns that.
    always_comb begin
        op_a = ReadData1;
        unique case (ForwardA)
            2'b10:   op_a = ALU_Result_Out;
            2'b01:   op_a = WbFwdData;
            default: op_a = ReadData1;
        endcase
        fwd_b = ReadData2;
        unique case (ForwardB)
            2'b10:   fwd_b = ALU_Result_Out;
            2'b01:   fwd_b = WbFwdData;
            default: fwd_b = ReadData2;
        endcase
    end

    assign alu_b = ALUSrc ? ImmediateData : fwd_b;
    assign shamt = alu_b[5:0];

    always_comb begin
        alu_op = AluAdd;
        unique case (ALUOp)
            2'b01: alu_op = AluSub;
            2'b10: begin
                unique case (Funct)
                    4'b0000: alu_op = AluAdd;
                    4'b1000: alu_op = AluSub;
                    4'b0111: alu_op = AluAnd;
                    4'b0110: alu_op = AluOr;
                    4'b0100: alu_op = AluXor;
                    4'b0001: alu_op = AluSll;
                    4'b0101: alu_op = AluSrl;
                    4'b1101: alu_op = AluSra;
                    default: alu_op = AluAdd;
                endcase
            end
            default: alu_op = AluAdd;
        endcase
    end

    always_comb begin
        alu_result = 64'd0;
        unique case (alu_op)
            AluAdd:  alu_result = op_a + alu_b;
            AluSub:  alu_result = op_a - alu_b;
            AluAnd:  alu_result = op_a & alu_b;
            AluOr:   alu_result = op_a | alu_b;
            AluXor:  alu_result = op_a ^ alu_b;
            AluSll:  alu_result = op_a << shamt;
            AluSrl:  alu_result = op_a >> shamt;
            AluSra:  alu_result = $unsigned($signed(op_a) >>> shamt);
            default: alu_result = op_a + alu_b;
        endcase
    end

    assign alu_zero      = (alu_result == 64'd0);
    assign branch_target = Inst_Addr + (ImmediateData << 1);
    assign branch_taken  = valid_in & M[2] &
                           (((Funct[2:0] == 3'b000) & alu_zero) |
                            ((Funct[2:0] == 3'b001) & ~alu_zero));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WB_Out            <= 2'd0;
            M_Out             <= 3'd0;
            rd_Out            <= 5'd0;
            valid_out         <= 1'b0;
            ALU_Result_Out    <= 64'd0;
            WriteData_Out     <= 64'd0;
            Zero_Out          <= 1'b0;
            Branch_Target_Out <= 64'd0;
            BranchTaken_Out   <= 1'b0;
        end else if (flush) begin
            WB_Out            <= 2'd0;
            M_Out             <= 3'd0;
            rd_Out            <= 5'd0;
            valid_out         <= 1'b0;
            ALU_Result_Out    <= 64'd0;
            WriteData_Out     <= 64'd0;
            Zero_Out          <= 1'b0;
            Branch_Target_Out <= 64'd0;
            BranchTaken_Out   <= 1'b0;
        end else if (!stall) begin
            WB_Out            <= valid_in ? WB : 2'd0;
            M_Out             <= valid_in ? M : 3'd0;
            rd_Out            <= rd;
            valid_out         <= valid_in;
            ALU_Result_Out    <= alu_result;
            WriteData_Out     <= fwd_b;
            Zero_Out          <= alu_zero;
            Branch_Target_Out <= branch_target;
            BranchTaken_Out   <= branch_taken;
        end
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), clock and reset first:
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 Inst_Addr, ReadData1, ReadData2, ImmediateData  in  64 each  ID/EX data fields.
REQ-005 rd  in  5  destination register; Funct  in  4  {Instruction[30], Instruction[14:12]}.
REQ-006 WB  in  2  {RegWrite, MemtoReg}; M  in  3  {Branch, MemRead, MemWrite}; ALUOp  in  2; ALUSrc  in  1.
REQ-007 valid_in  in  1  ID/EX holds a real instruction.
REQ-008 ForwardA, ForwardB  in  2 each  operand select: 00 register, 10 EX/MEM result, 01 WB data, 11 register.
REQ-009 WbFwdData  in  64  write-back stage forwarding value.
REQ-010 stall  in  1  hold EX/MEM contents; flush  in  1  insert bubble.
REQ-011 WB_Out  out  2; M_Out  out  3; rd_Out  out  5; valid_out  out  1.
REQ-012 ALU_Result_Out  out  64; WriteData_Out  out  64 (forwarded rs2 value); Zero_Out  out  1.
REQ-013 Branch_Target_Out  out  64; BranchTaken_Out  out  1.

Function
REQ-014 Operand A SHALL be ReadData1, ALU_Result_Out or WbFwdData per ForwardA; forwarded B SHALL be selected likewise per ForwardB.
REQ-015 ALU input 2 SHALL be ImmediateData when ALUSrc=1, else forwarded B.
REQ-016 ALU operation: ALUOp 00 add; 01 subtract; 11 add; 10 decoded from Funct: 0000 add, 1000 sub, 0111 and, 0110 or, 0100 xor, 0001 sll, 0101 srl, 1101 sra, any other add.
REQ-017 Shift amount SHALL be ALU input 2 [5:0]; sra SHALL sign-extend; add/sub SHALL wrap modulo 2^64, no overflow flag.
REQ-018 Zero SHALL be 1 iff the 64-bit ALU result equals 0.
REQ-019 Branch target SHALL be Inst_Addr + (ImmediateData << 1), modulo 2^64.
REQ-020 Branch taken SHALL be valid_in & M[2] & ((Funct[2:0]=000 & Zero) | (Funct[2:0]=001 & !Zero)); other Funct[2:0] never taken.
REQ-021 Latency: all outputs SHALL be registered, one cycle after inputs are sampled.
REQ-022 Priority at each edge: flush > stall > load.
REQ-023 Load (no stall, no flush): every output SHALL capture its combinational value; WB_Out, M_Out SHALL capture WB, M gated to 0 when valid_in=0; valid_out SHALL capture valid_in.
REQ-024 Stall without flush: every output SHALL hold its value.
REQ-025 Flush (regardless of stall): valid_out, WB_Out, M_Out, BranchTaken_Out SHALL be 0; all other outputs SHALL be 0.
REQ-026 ForwardA/B=10 SHALL use the current registered ALU_Result_Out even when valid_out=0; hazard control owns correctness.
REQ-027 BranchTaken_Out SHALL be asserted for exactly one cycle per taken branch unless stall holds it.

Reset
REQ-028 When reset=1, all outputs SHALL go to 0 immediately, independent of clk.
REQ-029 Reset deassertion SHALL be followed by normal load behaviour at the next rising edge; reset during stall or flush SHALL override both.

Verification
REQ-030 add: ALUOp=10, Funct=0000, ReadData1=5, ReadData2=7, ALUSrc=0, valid_in=1 -> next cycle ALU_Result_Out=12, Zero_Out=0, WB_Out=WB, valid_out=1.
REQ-031 beq: M=100, ALUOp=01, Funct=0000, ReadData1=ReadData2=9, Inst_Addr=0x100, Imm=8 -> Zero_Out=1, BranchTaken_Out=1, Branch_Target_Out=0x110; bne same data -> BranchTaken_Out=0.
REQ-032 Forwarding: prior result 0x20 registered, ForwardA=10, ForwardB=01, WbFwdData=3, sub -> ALU_Result_Out=0x1D, WriteData_Out=3.
REQ-033 sra: ReadData1=0x8000000000000000, Imm=4, ALUSrc=1, Funct=1101 -> 0xF800000000000000; sll by 64 (Imm=64) -> shift 0, result unchanged.
REQ-034 Stall two cycles with changing inputs -> outputs unchanged; stall+flush same cycle -> valid_out=0, WB_Out=0, M_Out=0.
REQ-035 Assert reset mid-cycle with valid_out=1, BranchTaken_Out=1 -> all outputs 0 before next clk edge.
